// File: rtl/hazard_sequencer_pkg.sv
// rtl/hazard_sequencer_pkg.sv - encodings and operand-forwarding helpers shared by the hazard sequencer
package hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_WAIT = 2'd1,
    HS_ERR  = 2'd2
  } hs_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [4:0] REG_ZERO   = 5'd0;

  // x0 is hardwired, so a write to it never produces a value worth forwarding.
  function automatic logic writes_reg(input logic [2:0] mode, input logic [4:0] rd);
    return (mode != NOREGWRITE) && (rd != REG_ZERO);
  endfunction

  function automatic logic [1:0] fwd_select(
    input logic       used,
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [2:0] wr_m,
    input logic [4:0] rd_w,
    input logic [2:0] wr_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (used && writes_reg(wr_m, rd_m) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (used && writes_reg(wr_w, rd_w) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - stall/flush/forward control and data-memory wait sequencing for the 5-stage core
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int CNT_W     = 32
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST_N,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [1:0]       RegReadD,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [1:0]       RegReadE,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [2:0]       RegWriteE,
  input  logic [2:0]       RegWriteM,
  input  logic [2:0]       RegWriteW,
  input  logic             MemToRegE,
  input  logic             BranchE,
  input  logic             JalrE,
  input  logic             JalD,
  input  logic             MemReqM,
  input  logic             DMemReady,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushF,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       Forward1E,
  output logic [1:0]       Forward2E,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents
);

  localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] WAIT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  hs_state_e            state_q;
  hs_state_e            state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q;
  logic [TIMEOUT_W-1:0] wait_cnt_d;
  logic                 mem_err_q;
  logic                 mem_err_d;

  logic mem_stall;
  logic redirect;
  logic load_use;
  logic stall_any;
  logic flush_event;

  always_comb begin
    mem_stall = ((state_q == HS_IDLE) && MemReqM && !DMemReady) ||
                ((state_q == HS_WAIT) && !DMemReady) ||
                (state_q == HS_ERR);
    redirect  = BranchE || JalrE;
    load_use  = MemToRegE && writes_reg(RegWriteE, RdE) &&
                (((RdE == Rs1D) && RegReadD[1]) || ((RdE == Rs2D) && RegReadD[0]));
  end

  // The counter lands on all-ones on the same edge that enters ERR, so it never wraps.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      HS_IDLE: begin
        if (MemReqM && !DMemReady) begin
          state_d    = HS_WAIT;
          wait_cnt_d = '0;
        end
      end
      HS_WAIT: begin
        if (DMemReady) begin
          state_d = HS_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
          if (wait_cnt_d == WAIT_MAX) begin
            state_d = HS_ERR;
          end
        end
      end
      HS_ERR: begin
        state_d = HS_ERR;
      end
      default: begin
        state_d = HS_IDLE;
      end
    endcase
    if (state_d == HS_ERR) begin
      mem_err_d = 1'b1;
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q    <= HS_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Priority: memory stall > redirect > load-use > JAL; reset forces bubbles everywhere.
  always_comb begin
    {StallF, StallD, StallE, StallM, StallW} = 5'b00000;
    {FlushF, FlushD, FlushE, FlushM, FlushW} = 5'b00000;
    Forward1E = FWD_RF;
    Forward2E = FWD_RF;
    if (!CPU_RST_N) begin
      {FlushF, FlushD, FlushE, FlushM, FlushW} = 5'b11111;
    end else begin
      Forward1E = fwd_select(RegReadE[1], Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      Forward2E = fwd_select(RegReadE[0], Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (mem_stall) begin
        {StallF, StallD, StallE, StallM} = 4'b1111;
        FlushW = 1'b1;
      end else if (redirect) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (JalD) begin
        FlushD = 1'b1;
      end
    end
  end

  always_comb begin
    stall_any   = StallF || StallD || StallE || StallM || StallW;
    flush_event = CPU_RST_N && !mem_stall && (redirect || (JalD && !load_use));
  end

  assign MemErr = mem_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CPU_CLK),
    .rst_n (CPU_RST_N),
    .inc   (stall_any),
    .clr   (1'b0),
    .count (StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CPU_CLK),
    .rst_n (CPU_RST_N),
    .inc   (flush_event),
    .clr   (1'b0),
    .count (FlushEvents)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - scoreboard bench for hazard_sequencer
module tb_hazard_sequencer;

  logic        CPU_CLK;
  logic        CPU_RST_N;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  RegReadD, RegReadE;
  logic [2:0]  RegWriteE, RegWriteM, RegWriteW;
  logic        MemToRegE, BranchE, JalrE, JalD, MemReqM, DMemReady;
  logic        StallF, StallD, StallE, StallM, StallW;
  logic        FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]  Forward1E, Forward2E;
  logic        MemErr;
  logic [31:0] StallCycles, FlushEvents;

  hazard_sequencer #(.TIMEOUT_W(4), .CNT_W(32)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegReadD(RegReadD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RegReadE(RegReadE),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .MemReqM(MemReqM), .DMemReady(DMemReady),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .Forward1E(Forward1E), .Forward2E(Forward2E), .MemErr(MemErr),
    .StallCycles(StallCycles), .FlushEvents(FlushEvents)
  );

  localparam logic [4:0] ST_NONE = 5'b00000;
  localparam logic [4:0] ST_MEM  = 5'b11110;
  localparam logic [4:0] ST_LU   = 5'b11000;
  localparam logic [4:0] FL_NONE = 5'b00000;
  localparam logic [4:0] FL_MEM  = 5'b00001;
  localparam logic [4:0] FL_LU   = 5'b00100;
  localparam logic [4:0] FL_RD   = 5'b01100;
  localparam logic [4:0] FL_JAL  = 5'b01000;
  localparam logic [4:0] FL_RST  = 5'b11111;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;
  logic [14:0] sb[$];
  logic [14:0] exp_v;
  logic [14:0] e;
  logic [14:0] obs;

  assign obs = {StallF, StallD, StallE, StallM, StallW,
                FlushF, FlushD, FlushE, FlushM, FlushW,
                Forward1E, Forward2E, MemErr};

  initial begin
    CPU_CLK = 1'b0;
    forever #5 CPU_CLK = ~CPU_CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [14:0] mk(input logic [4:0] st, input logic [4:0] fl,
                                     input logic [1:0] f1, input logic [1:0] f2, input logic err);
    return {st, fl, f1, f2, err};
  endfunction

  task automatic clear_in();
    Rs1D = 0; Rs2D = 0; RegReadD = 0; Rs1E = 0; Rs2E = 0; RegReadE = 0;
    RdE = 0; RdM = 0; RdW = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemToRegE = 0; BranchE = 0; JalrE = 0; JalD = 0; MemReqM = 0; DMemReady = 0;
  endtask

  task automatic set_load_use();
    MemToRegE = 1; RegWriteE = 3'd1; RdE = 5'd5; Rs1D = 5'd5; RegReadD = 2'b10;
  endtask

  task automatic set_fwd_m7();
    RdM = 5'd7; RdW = 5'd7; Rs2E = 5'd7; RegReadE = 2'b01; RegWriteM = 3'd1; RegWriteW = 3'd2;
  endtask

  task automatic test_reset();
    clear_in();
    CPU_RST_N = 1'b1;
    #2 CPU_RST_N = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CPU_CLK); #1;
      clear_in();
      case (c)
        0: begin set_fwd_m7(); MemReqM = 1; e = mk(ST_NONE, FL_RST, 2'b00, 2'b00, 1'b0); end
        1: begin BranchE = 1; JalD = 1; set_load_use(); e = mk(ST_NONE, FL_RST, 2'b00, 2'b00, 1'b0); end
        default: begin CPU_RST_N = 1'b1; e = mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0); end
      endcase
      sb.push_back(e);
      @(negedge CPU_CLK);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset c%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    checks++;
    if (StallCycles !== 32'd0 || FlushEvents !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", StallCycles, FlushEvents);
    end
  endtask

  task automatic test_memory_wait();
    for (int c = 0; c < 7; c++) begin
      @(posedge CPU_CLK); #1;
      clear_in();
      e = mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0);
      if (c < 3) begin
        MemReqM = 1; e = mk(ST_MEM, FL_MEM, 2'b00, 2'b00, 1'b0); exp_stall++;
      end else if (c == 3 || c == 5) begin
        MemReqM = 1; DMemReady = 1;
      end
      sb.push_back(e);
      @(negedge CPU_CLK);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL mem_wait c%0d got=%h exp=%h", c, obs, exp_v);
      end
      if (c == 4 || c == 6) begin
        checks++;
        if (StallCycles !== exp_stall) begin
          failures++;
          $display("FAIL mem_wait_stall_cycles c%0d got=%0d exp=%0d", c, StallCycles, exp_stall);
        end
      end
    end
  endtask

  task automatic test_jal_mem_stall();
    for (int c = 0; c < 4; c++) begin
      @(posedge CPU_CLK); #1;
      clear_in();
      case (c)
        0, 1: begin MemReqM = 1; JalD = 1; e = mk(ST_MEM, FL_MEM, 2'b00, 2'b00, 1'b0); exp_stall++; end
        2: begin MemReqM = 1; DMemReady = 1; JalD = 1; e = mk(ST_NONE, FL_JAL, 2'b00, 2'b00, 1'b0); exp_flush++; end
        default: e = mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0);
      endcase
      sb.push_back(e);
      @(negedge CPU_CLK);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL jal_mem_stall c%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    checks++;
    if (StallCycles !== exp_stall || FlushEvents !== exp_flush) begin
      failures++;
      $display("FAIL jal_mem_stall_counters got=%0d/%0d exp=%0d/%0d", StallCycles, FlushEvents, exp_stall, exp_flush);
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 8; c++) begin
      @(posedge CPU_CLK); #1;
      clear_in();
      e = mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0);
      case (c)
        0: begin set_load_use(); e = mk(ST_LU, FL_LU, 2'b00, 2'b00, 1'b0); exp_stall++; end
        1: begin set_load_use(); RdE = 5'd0; Rs1D = 5'd0; end
        2: begin set_load_use(); Rs1D = 5'd3; Rs2D = 5'd5; RegReadD = 2'b01; e = mk(ST_LU, FL_LU, 2'b00, 2'b00, 1'b0); exp_stall++; end
        3: begin set_load_use(); Rs2D = 5'd3; RegReadD = 2'b01; end
        4: begin set_load_use(); JalD = 1; e = mk(ST_LU, FL_LU, 2'b00, 2'b00, 1'b0); exp_stall++; end
        5: begin JalD = 1; e = mk(ST_NONE, FL_JAL, 2'b00, 2'b00, 1'b0); exp_flush++; end
        6: begin set_load_use(); RegWriteE = 3'd0; end
        default: ;
      endcase
      sb.push_back(e);
      @(negedge CPU_CLK);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL load_use c%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    checks++;
    if (StallCycles !== exp_stall || FlushEvents !== exp_flush) begin
      failures++;
      $display("FAIL load_use_counters got=%0d/%0d exp=%0d/%0d", StallCycles, FlushEvents, exp_stall, exp_flush);
    end
  endtask

  task automatic test_load_use_branch();
    for (int c = 0; c < 4; c++) begin
      @(posedge CPU_CLK); #1;
      clear_in();
      e = mk(ST_NONE, FL_RD, 2'b00, 2'b00, 1'b0);
      case (c)
        0: begin set_load_use(); BranchE = 1; exp_flush++; end
        1: begin set_load_use(); JalrE = 1; JalD = 1; exp_flush++; end
        2: begin BranchE = 1; exp_flush++; end
        default: e = mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0);
      endcase
      sb.push_back(e);
      @(negedge CPU_CLK);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL load_use_branch c%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    checks++;
    if (StallCycles !== exp_stall || FlushEvents !== exp_flush) begin
      failures++;
      $display("FAIL load_use_branch_counters got=%0d/%0d exp=%0d/%0d", StallCycles, FlushEvents, exp_stall, exp_flush);
    end
  endtask

  task automatic test_forwarding();
    for (int c = 0; c < 10; c++) begin
      @(posedge CPU_CLK); #1;
      clear_in();
      e = mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0);
      case (c)
        0: begin set_fwd_m7(); e = mk(ST_NONE, FL_NONE, 2'b00, 2'b10, 1'b0); end
        1: begin set_fwd_m7(); RegWriteM = 3'd0; e = mk(ST_NONE, FL_NONE, 2'b00, 2'b01, 1'b0); end
        2: begin set_fwd_m7(); RegWriteM = 3'd0; RegWriteW = 3'd0; end
        3: begin set_fwd_m7(); RegReadE = 2'b10; Rs1E = 5'd3; end
        4: begin
          Rs1E = 5'd9; Rs2E = 5'd9; RdM = 5'd9; RdW = 5'd9; RegReadE = 2'b11;
          RegWriteM = 3'd1; RegWriteW = 3'd1; e = mk(ST_NONE, FL_NONE, 2'b10, 2'b10, 1'b0);
        end
        5: begin RegReadE = 2'b11; RegWriteM = 3'd1; RegWriteW = 3'd1; end
        6: begin
          Rs1E = 5'd4; RdW = 5'd4; RegWriteW = 3'd3; RdM = 5'd6; RegWriteM = 3'd1;
          RegReadE = 2'b10; e = mk(ST_NONE, FL_NONE, 2'b01, 2'b00, 1'b0);
        end
        7: begin set_fwd_m7(); MemReqM = 1; e = mk(ST_MEM, FL_MEM, 2'b00, 2'b10, 1'b0); exp_stall++; end
        8: begin set_fwd_m7(); MemReqM = 1; DMemReady = 1; e = mk(ST_NONE, FL_NONE, 2'b00, 2'b10, 1'b0); end
        default: ;
      endcase
      sb.push_back(e);
      @(negedge CPU_CLK);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL forwarding c%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    checks++;
    if (StallCycles !== exp_stall) begin
      failures++;
      $display("FAIL forwarding_stall_cycles got=%0d exp=%0d", StallCycles, exp_stall);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int c = 0; c < 4; c++) begin
      @(posedge CPU_CLK); #1;
      clear_in();
      MemReqM = 1;
      case (c)
        0, 1: e = mk(ST_MEM, FL_MEM, 2'b00, 2'b00, 1'b0);
        2: begin CPU_RST_N = 1'b0; e = mk(ST_NONE, FL_RST, 2'b00, 2'b00, 1'b0); exp_stall = 0; exp_flush = 0; end
        default: begin CPU_RST_N = 1'b1; DMemReady = 1; e = mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0); end
      endcase
      sb.push_back(e);
      @(negedge CPU_CLK);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_mid_wait c%0d got=%h exp=%h", c, obs, exp_v);
      end
    end
    checks++;
    if (StallCycles !== exp_stall || FlushEvents !== exp_flush) begin
      failures++;
      $display("FAIL reset_mid_wait_counters got=%0d/%0d exp=%0d/%0d", StallCycles, FlushEvents, exp_stall, exp_flush);
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 22; c++) begin
      @(posedge CPU_CLK); #1;
      clear_in();
      if (c <= 15) begin
        MemReqM = 1; e = mk(ST_MEM, FL_MEM, 2'b00, 2'b00, 1'b0); exp_stall++;
      end else if (c <= 18) begin
        if (c == 17) begin DMemReady = 1; JalD = 1; BranchE = 1; set_load_use(); end
        e = mk(ST_MEM, FL_MEM, 2'b00, 2'b00, 1'b1); exp_stall++;
      end else if (c == 19) begin
        CPU_RST_N = 1'b0; exp_stall = 0; exp_flush = 0;
        e = mk(ST_NONE, FL_RST, 2'b00, 2'b00, 1'b0);
      end else begin
        CPU_RST_N = 1'b1;
        if (c == 21) begin MemReqM = 1; DMemReady = 1; end
        e = mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0);
      end
      sb.push_back(e);
      @(negedge CPU_CLK);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL timeout c%0d got=%h exp=%h", c, obs, exp_v);
      end
      if (c == 18 || c == 19) begin
        checks++;
        if (StallCycles !== exp_stall - ((c == 18) ? 32'd1 : 32'd0)) begin
          failures++;
          $display("FAIL timeout_stall_cycles c%0d got=%0d exp=%0d", c, StallCycles,
                   exp_stall - ((c == 18) ? 32'd1 : 32'd0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_memory_wait();
    test_jal_mem_stall();
    test_load_use();
    test_load_use_branch();
    test_forwarding();
    test_reset_mid_wait();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
